// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3,
    StFailed   = 3'd4
  } state_t;

  // Counter width for a bound n, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and system-facing signals of the lock supervisor.
// Statistics counters exist only when LOCK_STATS_EN is defined.
interface pll_lock_supervisor_if #(
  parameter int unsigned CNT_W = 8
);
  import pll_sup_pkg::*;

  logic               pll_locked;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fail;
  logic [STATE_W-1:0] state;
  logic [2:0]         retries;
`ifdef LOCK_STATS_EN
  logic [CNT_W-1:0]   loss_count;
  logic [CNT_W-1:0]   relock_count;
`endif

  modport master (
    input  pll_locked,
`ifdef LOCK_STATS_EN
    output loss_count, relock_count,
`endif
    output pll_rst, sys_rst, ready, fail, state, retries
  );

  modport slave (
    output pll_locked,
`ifdef LOCK_STATS_EN
    input  loss_count, relock_count,
`endif
    input  pll_rst, sys_rst, ready, fail, state, retries
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser; the chain is deliberately left without reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises PLL reset/lock on the reference clock and generates the system reset.
// Optional lock statistics counters are enabled with LOCK_STATS_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                     clk,
  input logic                     rst,
  pll_lock_supervisor_if.master   bus
);

  localparam int unsigned PulseW  = cnt_w(RST_PULSE);
  localparam int unsigned TmoW    = cnt_w(LOCK_TIMEOUT);
  localparam int unsigned SettleW = cnt_w(SETTLE_CYCLES);

  if (SYNC_STAGES < 2 || RST_PULSE < 1 || MAX_RETRIES < 1 || MAX_RETRIES > 7 || CNT_W < 1)
  begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  logic locked_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_locked (
    .clk (clk),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  state_t             state_q, state_d;
  logic [PulseW-1:0]  pulse_q, pulse_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [2:0]         retries_q, retries_d;
  logic               pll_rst_q, sys_rst_q, ready_q, fail_q;

  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;
    retries_d = retries_q;
    unique case (state_q)
      StResetPll: begin
        if (pulse_q == PulseW'(RST_PULSE - 1)) begin
          state_d = StWaitLock;
          tmo_d   = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d  = StSettle;
          settle_d = '0;
        end else if (tmo_q == TmoW'(LOCK_TIMEOUT - 1)) begin
          retries_d = retries_q + 3'd1;
          if (retries_d == 3'(MAX_RETRIES)) begin
            state_d = StFailed;
          end else begin
            state_d = StResetPll;
            pulse_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StSettle: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          tmo_d   = '0;
        end else if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
          state_d   = StRun;
          retries_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRun: begin
        // Lock loss re-waits without pulsing the PLL reset.
        if (!locked_s) begin
          state_d = StWaitLock;
          tmo_d   = '0;
        end
      end
      StFailed: begin
        state_d = StFailed;
      end
      default: begin
        state_d = StResetPll;
        pulse_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StResetPll;
      pulse_q   <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      retries_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      retries_q <= retries_d;
      pll_rst_q <= (state_d == StResetPll) || (state_d == StFailed);
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
      fail_q    <= (state_d == StFailed);
    end
  end

  assign bus.state   = state_q;
  assign bus.pll_rst = pll_rst_q;
  assign bus.sys_rst = sys_rst_q;
  assign bus.ready   = ready_q;
  assign bus.fail    = fail_q;
  assign bus.retries = retries_q;

`ifdef LOCK_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] loss_q, relock_q;
  logic             loss_ev, relock_ev;

  assign loss_ev   = (state_q == StRun) && (state_d == StWaitLock);
  assign relock_ev = (state_q != StRun) && (state_d == StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q   <= '0;
      relock_q <= '0;
    end else begin
      if (loss_ev && loss_q != CntMax) begin
        loss_q <= loss_q + 1'b1;
      end
      if (relock_ev && relock_q != CntMax) begin
        relock_q <= relock_q + 1'b1;
      end
    end
  end

  assign bus.loss_count   = loss_q;
  assign bus.relock_count = relock_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock activity,
// checked every cycle against a timestamp-based behavioural model.
module tb_pll_lock_supervisor;

  localparam int SS = 2;
  localparam int RP = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pll_lock_supervisor_if #(.CNT_W(CW)) bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES   (SS),
    .RST_PULSE     (RP),
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SC),
    .MAX_RETRIES   (MR),
    .CNT_W         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: state plus the cycle stamp of its entry; lock seen through an SS-deep delay line.
  int m_state = 0;
  int m_enter = 0;
  int cyc = 0;
  int m_retries = 0;
  int m_loss = 0;
  int m_relock = 0;
  bit hist[$];

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic enter(input int s);
    m_state = s;
    m_enter = cyc;
  endtask

  initial begin
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);
  end

  always @(posedge clk) begin
    bit ls;
    int el;
    ls = hist.pop_front();
    hist.push_back(bus.pll_locked);
    cyc++;
    el = cyc - m_enter;
    if (rst) begin
      enter(0);
      m_retries = 0;
      m_loss = 0;
      m_relock = 0;
    end else begin
      case (m_state)
        0: if (el == RP) enter(1);
        1: begin
          if (ls) enter(2);
          else if (el == LT) begin
            m_retries++;
            if (m_retries == MR) enter(4);
            else enter(0);
          end
        end
        2: begin
          if (!ls) enter(1);
          else if (el == SC) begin
            enter(3);
            m_retries = 0;
            m_relock = sat(m_relock);
          end
        end
        3: begin
          if (!ls) begin
            enter(1);
            m_loss = sat(m_loss);
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(bus.state), m_state);
      chk("pll_rst", int'(bus.pll_rst), int'(m_state == 0 || m_state == 4));
      chk("sys_rst", int'(bus.sys_rst), int'(m_state != 3));
      chk("ready", int'(bus.ready), int'(m_state == 3));
      chk("fail", int'(bus.fail), int'(m_state == 4));
      chk("retries", int'(bus.retries), m_retries);
`ifdef LOCK_STATS_EN
      chk("loss_count", int'(bus.loss_count), m_loss);
      chk("relock_count", int'(bus.relock_count), m_relock);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(input string name, input int exp_state);
    chk({name, "_dut_state"}, int'(bus.state), exp_state);
    chk({name, "_model_state"}, m_state, exp_state);
  endtask

  initial begin
    int len;
    int total;
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(3);
    rst = 1'b0;

    // Power-up pulse then wait for lock.
    tick(3);
    pin("s1_pulse", 0);
    chk("s1_pll_rst_hi", int'(bus.pll_rst), 1);
    tick(1);
    pin("s1_wait", 1);
    chk("s1_pll_rst_lo", int'(bus.pll_rst), 0);

    // Lock arrives 10 cycles into WAIT_LOCK.
    tick(10);
    bus.pll_locked = 1'b1;
    tick(2);
    pin("s2_sync", 1);
    tick(1);
    pin("s2_settle", 2);
    tick(7);
    pin("s2_settle_end", 2);
    tick(1);
    pin("s2_run", 3);
    chk("s2_sys_rst", int'(bus.sys_rst), 0);
    chk("s2_ready", int'(bus.ready), 1);
    chk("s2_retries", int'(bus.retries), 0);

    // Lock loss in RUN.
    tick(5);
    bus.pll_locked = 1'b0;
    tick(2);
    pin("s4_still_run", 3);
    tick(1);
    pin("s4_wait", 1);
    chk("s4_sys_rst", int'(bus.sys_rst), 1);
    chk("s4_pll_rst", int'(bus.pll_rst), 0);
`ifdef LOCK_STATS_EN
    chk("s4_loss_count", int'(bus.loss_count), 1);
`endif

    // Relock with a 3-cycle glitch inside SETTLE.
    bus.pll_locked = 1'b1;
    tick(3);
    pin("s3_settle", 2);
    tick(2);
    bus.pll_locked = 1'b0;
    tick(3);
    pin("s3_glitch_wait", 1);
    bus.pll_locked = 1'b1;
    tick(3);
    pin("s3_resettle", 2);
    tick(7);
    pin("s3_resettle_end", 2);
    tick(1);
    pin("s3_run", 3);
`ifdef LOCK_STATS_EN
    chk("s3_relock_count", int'(bus.relock_count), 2);
`endif

    // Two timeouts lead to FAILED.
    bus.pll_locked = 1'b0;
    tick(3);
    pin("s5_wait", 1);
    tick(31);
    pin("s5_pre_tmo", 1);
    tick(1);
    pin("s5_retry", 0);
    chk("s5_retries1", int'(bus.retries), 1);
    tick(3);
    pin("s5_pulse", 0);
    tick(1);
    pin("s5_wait2", 1);
    tick(31);
    pin("s5_pre_tmo2", 1);
    tick(1);
    pin("s5_failed", 4);
    chk("s5_fail", int'(bus.fail), 1);
    chk("s5_retries2", int'(bus.retries), 2);
    bus.pll_locked = 1'b1;
    tick(20);
    pin("s5_sticky", 4);
    chk("s5_pll_rst_stuck", int'(bus.pll_rst), 1);

    // rst out of FAILED, then lock on the exact timeout cycle.
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    tick(1);
    pin("s6_rst", 0);
    chk("s6_fail", int'(bus.fail), 0);
    chk("s6_retries", int'(bus.retries), 0);
    chk("s6_sys_rst", int'(bus.sys_rst), 1);
`ifdef LOCK_STATS_EN
    chk("s6_loss_count", int'(bus.loss_count), 0);
`endif
    tick(2);
    rst = 1'b0;
    tick(4);
    pin("s6_wait", 1);
    tick(32);
    pin("s6_retry", 0);
    tick(4);
    pin("s6_wait2", 1);
    tick(29);
    bus.pll_locked = 1'b1;
    tick(2);
    pin("s6_pre_edge", 1);
    tick(1);
    pin("s6_lock_wins", 2);
    chk("s6_retries_kept", int'(bus.retries), 1);
    tick(8);
    pin("s6_run", 3);
    chk("s6_retries_clr", int'(bus.retries), 0);

    // Random lock activity with occasional resets.
    total = 0;
    while (total < 4000) begin
      len = $urandom_range(1, 60);
      bus.pll_locked = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        total += 2;
      end
      tick(len);
      total += len;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
